// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1/8E1 UART receiver emitting 9-bit {error, byte} words with a one-cycle strobe
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN = 1
) (
  input  logic       clk_I,
  input  logic       reset_I,
  input  logic       rx_I,
  output logic [8:0] data_O,
  output logic       new_data_O,
  output logic       busy_O
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] bit_cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic perr;
  logic half, full;
  assign half = bit_cnt == HALF;
  assign full = bit_cnt == FULL;
  // two-flop synchronizer, reset to the idle-high line level
  always_ff @(posedge clk_I)
    if (reset_I) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, rx_I};
  // state register
  always_ff @(posedge clk_I)
    if (reset_I) state <= IDLE;
    else state <= state_n;
  // next-state: mid-bit sampling drives every transition
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = half ? (rx_s ? IDLE : DATA) : START;
      DATA:      state_n = (full && idx == 3'd7) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:    state_n = full ? STOP : PARITY;
      STOP:      state_n = full ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb busy_O = state != IDLE;
  // sample counter, bit capture, parity check and word emission
  always_ff @(posedge clk_I)
    if (reset_I) begin
      bit_cnt <= '0;
      idx <= '0;
      shreg <= '0;
      perr <= 1'b0;
      data_O <= '0;
      new_data_O <= 1'b0;
    end else begin
      bit_cnt <= (state == IDLE || state == WAIT_HIGH || (state == START && half) || full) ? '0 : bit_cnt + CW'(1);
      new_data_O <= state == STOP && full;
      if (state == START) begin
        idx <= '0;
        perr <= 1'b0;
      end
      if (state == DATA && full) begin
        shreg[idx] <= rx_s;
        idx <= idx + 3'd1;
      end
      if (state == PARITY && full) perr <= rx_s ^ (^shreg);
      if (state == STOP && full) data_O <= {perr | ~rx_s, shreg};
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames into 8E1 and 8N1 receivers checked against a frame-level model
module tb_uart_rx;
  localparam int N = 16;
  localparam int LAT_E = 8 + 10 * N + 2;
  localparam int LAT_N = 8 + 9 * N + 2;
  typedef struct {
    logic [8:0] word;
    int start;
  } exp_t;
  logic clk = 1'b0;
  logic reset_I = 1'b1;
  logic rx_e = 1'b1;
  logic rx_n = 1'b1;
  logic [8:0] data_e, data_n;
  logic new_data_e, new_data_n, busy_e, busy_n;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  exp_t exp_e[$];
  exp_t exp_n[$];
  int strobes_e[$];
  int strobes_n[$];
  logic prev_e = 1'b0;
  logic prev_n = 1'b0;
  exp_t xe, xn;

  uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1)) u_e (
    .clk_I(clk), .reset_I(reset_I), .rx_I(rx_e),
    .data_O(data_e), .new_data_O(new_data_e), .busy_O(busy_e)
  );
  uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(0)) u_n (
    .clk_I(clk), .reset_I(reset_I), .rx_I(rx_n),
    .data_O(data_n), .new_data_O(new_data_n), .busy_O(busy_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int got, input int exp);
    n_assert++;
    assert (got >= exp - 1 && got <= exp + 1) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d+-1", tag, got, exp);
    end
  endtask

  // each strobe must be a single cycle, be expected, carry the modelled word and arrive on time
  always @(negedge clk) begin
    if (new_data_e) begin
      chk("width_e", {31'd0, prev_e}, 32'd0);
      chk("expected_e", {31'd0, exp_e.size() > 0}, 32'd1);
      if (exp_e.size() > 0) begin
        xe = exp_e.pop_front();
        chk("data_e", {23'd0, data_e}, {23'd0, xe.word});
        chk_lat("latency_e", cyc - xe.start, LAT_E);
      end
      strobes_e.push_back(cyc);
    end
    if (new_data_n) begin
      chk("width_n", {31'd0, prev_n}, 32'd0);
      chk("expected_n", {31'd0, exp_n.size() > 0}, 32'd1);
      if (exp_n.size() > 0) begin
        xn = exp_n.pop_front();
        chk("data_n", {23'd0, data_n}, {23'd0, xn.word});
        chk_lat("latency_n", cyc - xn.start, LAT_N);
      end
      strobes_n.push_back(cyc);
    end
    prev_e = new_data_e;
    prev_n = new_data_n;
  end

  task automatic drive(input bit sel, input logic v, input int cycles);
    if (sel) rx_n = v;
    else rx_e = v;
    repeat (cycles) @(negedge clk);
  endtask

  // sel 0: 8E1 receiver, sel 1: 8N1 receiver
  task automatic send(input bit sel, input logic [7:0] b, input logic pb, input logic sb, input int gap);
    exp_t x;
    x.word = {(sel ? 1'b0 : (^b ^ pb)) | ~sb, b};
    x.start = cyc;
    if (sel) exp_n.push_back(x);
    else exp_e.push_back(x);
    drive(sel, 1'b0, N);
    for (int i = 0; i < 8; i++) drive(sel, b[i], N);
    if (!sel) drive(sel, pb, N);
    drive(sel, sb, N);
    if (gap > 0) drive(sel, 1'b1, gap * N);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    logic pb, sb;
    logic [7:0] b2b [4];
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_data_e", {23'd0, data_e}, 32'd0);
    chk("rst_new_e", {31'd0, new_data_e}, 32'd0);
    chk("rst_busy_e", {31'd0, busy_e}, 32'd0);
    chk("rst_data_n", {23'd0, data_n}, 32'd0);
    chk("rst_busy_n", {31'd0, busy_n}, 32'd0);
    reset_I = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h5A, 1'b0, 1'b1, 2);
    chk("single_count", strobes_e.size(), 1);
    chk("single_busy", {31'd0, busy_e}, 32'd0);
    send(0, 8'hA5, 1'b1, 1'b1, 2);
    chk("perr_count", strobes_e.size(), 2);
    k = strobes_e.size();
    send(0, 8'h00, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 64 * N);
    chk("break_one_word", strobes_e.size(), k + 1);
    chk("break_busy_high", {31'd0, busy_e}, 32'd1);
    drive(0, 1'b1, 6);
    chk("break_busy_low", {31'd0, busy_e}, 32'd0);
    send(0, 8'h3C, 1'b0, 1'b1, 2);
    chk("after_break_count", strobes_e.size(), k + 2);
    k = strobes_e.size();
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 10);
    chk("glitch_busy", {31'd0, busy_e}, 32'd0);
    chk("glitch_no_strobe", strobes_e.size(), k);
    send(0, 8'h81, 1'b0, 1'b1, 2);
    chk("after_glitch_count", strobes_e.size(), k + 1);
    k = strobes_e.size();
    for (int i = 0; i < 4; i++) send(0, b2b[i], ^b2b[i], 1'b1, 0);
    drive(0, 1'b1, 2 * N);
    chk("b2b_e_count", strobes_e.size(), k + 4);
    for (int i = 0; i < 3; i++) chk("b2b_e_spacing", strobes_e[k + i + 1] - strobes_e[k + i], 11 * N);
    k = strobes_n.size();
    for (int i = 0; i < 4; i++) send(1, b2b[i], 1'b0, 1'b1, 0);
    drive(1, 1'b1, 2 * N);
    chk("b2b_n_count", strobes_n.size(), k + 4);
    for (int i = 0; i < 3; i++) chk("b2b_n_spacing", strobes_n[k + i + 1] - strobes_n[k + i], 10 * N);
    k = strobes_e.size();
    drive(0, 1'b0, N);
    drive(0, 1'b1, N);
    chk("midframe_busy", {31'd0, busy_e}, 32'd1);
    reset_I = 1'b1;
    @(negedge clk);
    reset_I = 1'b0;
    chk("midrst_busy", {31'd0, busy_e}, 32'd0);
    chk("midrst_data_e", {23'd0, data_e}, 32'd0);
    chk("midrst_data_n", {23'd0, data_n}, 32'd0);
    drive(0, 1'b1, 12 * N);
    chk("midrst_no_strobe", strobes_e.size(), k);
    chk("midrst_data_hold", {23'd0, data_e}, 32'd0);
    send(0, 8'h12, 1'b0, 1'b1, 2);
    chk("after_rst_count", strobes_e.size(), k + 1);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      pb = (^b) ^ ($urandom_range(0, 3) == 0);
      sb = $urandom_range(0, 4) != 0;
      send(0, b, pb, sb, sb ? $urandom_range(0, 2) : $urandom_range(1, 2));
      b = 8'($urandom);
      sb = $urandom_range(0, 4) != 0;
      send(1, b, 1'b0, sb, sb ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    drive(0, 1'b1, 2 * N);
    chk("drain_e", exp_e.size(), 0);
    chk("drain_n", exp_n.size(), 0);
    chk("final_busy_e", {31'd0, busy_e}, 32'd0);
    chk("final_busy_n", {31'd0, busy_n}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
